i2c_reg_arbiter: RTL and testbench

- Owns the 20-byte PID parameter register bank at I2C index 0x40..0x53.
- Arbitrates that bank between the I2C slave RAM port (write/read strobes, 8-bit index) and the PID core's request/ack port.
- Buffers one I2C write and holds it off while the core asserts a lock, so the core never sees a parameter change mid-computation.
- Signals committed updates and error conditions to the rest of the design.

---
 rtl/i2c_reg_arbiter.sv | 139 +++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// PID parameter bank shared between the I2C slave RAM port and the PID core.
// Holds one buffered I2C write, commits it when unlocked, and alternates priority with core accesses.
module i2c_reg_arbiter #(
  parameter logic [7:0]  BASE_ADDR = 8'h40,
  parameter int unsigned NUM_REGS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_write,
  input  logic       i2c_read,
  input  logic [7:0] i2c_index,
  input  logic [7:0] i2c_wdata,
  output logic [7:0] i2c_rdata,
  input  logic       core_req,
  input  logic       core_we,
  input  logic [4:0] core_addr,
  input  logic [7:0] core_wdata,
  output logic [7:0] core_rdata,
  output logic       core_ack,
  input  logic       core_lock,
  output logic       cfg_update,
  output logic [4:0] cfg_index,
  output logic       pend_valid,
  output logic       err_ovf,
  output logic       err_addr,
  input  logic       clr_flags
);

  typedef enum logic [1:0] {IDLE, CORE, ACK} state_t;

  localparam logic [7:0] NUM_I2C  = 8'(NUM_REGS);
  localparam logic [4:0] NUM_CORE = 5'(NUM_REGS);

  logic [7:0] bank [NUM_REGS];
  state_t     state, state_nx;
  logic       prio_core, prio_core_nx;
  logic       write_q;
  logic [4:0] pend_addr;
  logic [7:0] pend_data;
  logic [7:0] i2c_off;
  logic       i2c_hit, core_hit;
  logic       wr_event, elig, commit;
  logic       read_unused;

  assign read_unused = i2c_read;
  // Subtraction wraps indices below BASE_ADDR into the out-of-range zone.
  assign i2c_off   = i2c_index - BASE_ADDR;
  assign i2c_hit   = i2c_off < NUM_I2C;
  assign core_hit  = core_addr < NUM_CORE;
  assign wr_event  = i2c_write & ~write_q;
  assign elig      = pend_valid & ~core_lock;
  assign i2c_rdata = i2c_hit ? bank[i2c_off[4:0]] : 8'h00;

  always_comb begin
    state_nx     = state;
    prio_core_nx = prio_core;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req) begin
          if (elig && !prio_core) begin
            commit       = 1'b1;
            prio_core_nx = 1'b1;
          end else begin
            state_nx     = CORE;
            prio_core_nx = 1'b0;
          end
        end else begin
          commit = elig;
        end
      end
      CORE: state_nx = ACK;
      ACK: begin
        commit   = elig;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prio_core <= 1'b0;
    end else begin
      state     <= state_nx;
      prio_core <= prio_core_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank       <= '{default: '0};
      write_q    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      cfg_update <= 1'b0;
      cfg_index  <= '0;
      core_rdata <= '0;
      core_ack   <= 1'b0;
      err_ovf    <= 1'b0;
      err_addr   <= 1'b0;
    end else begin
      write_q    <= i2c_write;
      cfg_update <= commit;
      core_ack   <= (state == CORE);
      if (commit) begin
        bank[pend_addr] <= pend_data;
        cfg_index       <= pend_addr;
      end
      if (state == CORE) begin
        if (!core_hit)
          core_rdata <= '0;
        else if (core_we)
          bank[core_addr] <= core_wdata;
        else
          core_rdata <= bank[core_addr];
      end
      if (wr_event && i2c_hit) begin
        pend_addr  <= i2c_off[4:0];
        pend_data  <= i2c_wdata;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      // Sets are evaluated after the clear so they win on the same edge.
      if (clr_flags) begin
        err_ovf  <= 1'b0;
        err_addr <= 1'b0;
      end
      if (wr_event && i2c_hit && pend_valid && !commit)
        err_ovf <= 1'b1;
      if ((wr_event && !i2c_hit) || (state == CORE && !core_hit))
        err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Bench for i2c_reg_arbiter: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_i2c_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i2c_write = 1'b0;
  logic       i2c_read = 1'b0;
  logic [7:0] i2c_index = '0;
  logic [7:0] i2c_wdata = '0;
  logic [7:0] i2c_rdata;
  logic       core_req = 1'b0;
  logic       core_we = 1'b0;
  logic [4:0] core_addr = '0;
  logic [7:0] core_wdata = '0;
  logic [7:0] core_rdata;
  logic       core_ack;
  logic       core_lock = 1'b0;
  logic       cfg_update;
  logic [4:0] cfg_index;
  logic       pend_valid;
  logic       err_ovf;
  logic       err_addr;
  logic       clr_flags = 1'b0;

  int vecs = 0;
  int errs = 0;

  i2c_reg_arbiter dut (
    .clk(clk), .rst(rst),
    .i2c_write(i2c_write), .i2c_read(i2c_read),
    .i2c_index(i2c_index), .i2c_wdata(i2c_wdata),
    .i2c_rdata(i2c_rdata),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack),
    .core_lock(core_lock),
    .cfg_update(cfg_update), .cfg_index(cfg_index),
    .pend_valid(pend_valid),
    .err_ovf(err_ovf), .err_addr(err_addr),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       w;
    logic [7:0] idx;
    logic [7:0] wd;
    logic       lock;
    logic       clr;
    logic       pend;
    logic       upd;
    logic [4:0] cidx;
    logic       ovf;
    logic       ea;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [15];

  // Reference model: a bank array, a one-deep pending-write queue and
  // the number of cycles the current core transaction has been served.
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] m_bank [20];
  wr_t        m_pend [$];
  int         m_phase;
  bit         m_turn;
  bit         m_wq;
  bit         m_upd;
  logic [4:0] m_cidx;
  bit         m_ovf;
  bit         m_ea;
  bit         m_ack;
  logic [7:0] m_rd;

  task automatic m_reset();
    foreach (m_bank[i]) m_bank[i] = 8'h00;
    m_pend.delete();
    m_phase = 0;
    m_turn  = 1'b0;
    m_wq    = 1'b0;
    m_upd   = 1'b0;
    m_cidx  = '0;
    m_ovf   = 1'b0;
    m_ea    = 1'b0;
    m_ack   = 1'b0;
    m_rd    = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] idx);
    int off;
    off = int'(idx) - 'h40;
    if (off >= 0 && off < 20) return m_bank[off];
    return 8'h00;
  endfunction

  task automatic m_edge();
    bit  ev;
    bit  ready;
    bit  commit;
    bit  grant;
    int  off;
    wr_t p;
    ev     = i2c_write && !m_wq;
    ready  = m_pend.size() != 0 && !core_lock;
    commit = 1'b0;
    grant  = 1'b0;
    if (m_phase == 0 && core_req) begin
      if (ready && !m_turn) begin
        commit = 1'b1;
        m_turn = 1'b1;
      end else begin
        grant  = 1'b1;
        m_turn = 1'b0;
      end
    end else if (m_phase != 1) begin
      commit = ready;
    end
    m_upd = commit;
    if (commit) begin
      p = m_pend.pop_front();
      m_bank[p.a] = p.d;
      m_cidx = p.a;
    end
    m_ack = (m_phase == 1);
    if (clr_flags) begin
      m_ovf = 1'b0;
      m_ea  = 1'b0;
    end
    if (m_phase == 1) begin
      if (core_addr < 20) begin
        if (core_we) m_bank[core_addr] = core_wdata;
        else m_rd = m_bank[core_addr];
      end else begin
        m_rd = 8'h00;
        m_ea = 1'b1;
      end
    end
    off = int'(i2c_index) - 'h40;
    if (ev) begin
      if (off >= 0 && off < 20) begin
        if (m_pend.size() != 0) m_ovf = 1'b1;
        m_pend.delete();
        p.a = 5'(off);
        p.d = i2c_wdata;
        m_pend.push_back(p);
      end else begin
        m_ea = 1'b1;
      end
    end
    m_phase = grant ? 1 : (m_phase == 1 ? 2 : 0);
    m_wq = i2c_write;
  endtask

  initial begin
    tbl = '{
      '{1'b1, 8'h45, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 8'h45, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 8'hA7},
      '{1'b1, 8'h45, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 8'hA7},
      '{1'b1, 8'h45, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 8'hA7},
      '{1'b0, 8'h45, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 8'hA7},
      '{1'b1, 8'h40, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 8'h00},
      '{1'b0, 8'h40, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 8'h00},
      '{1'b1, 8'h40, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 8'h00},
      '{1'b0, 8'h40, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 8'h00},
      '{1'b0, 8'h40, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h22},
      '{1'b0, 8'h40, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h22},
      '{1'b1, 8'h54, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00},
      '{1'b0, 8'h54, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 8'h3F, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00},
      '{1'b0, 8'h53, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00}
    };

    #1;
    chk("reset_hold", {i2c_rdata, core_rdata, core_ack, cfg_update,
        cfg_index, pend_valid, err_ovf, err_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("reset_release", {core_rdata, core_ack, cfg_update,
        cfg_index, pend_valid, err_ovf, err_addr}, 32'h0);

    foreach (tbl[i]) begin
      i2c_write = tbl[i].w;
      i2c_index = tbl[i].idx;
      i2c_wdata = tbl[i].wd;
      core_lock = tbl[i].lock;
      clr_flags = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i),
          {core_ack, pend_valid, cfg_update, cfg_index,
           err_ovf, err_addr, i2c_rdata},
          {1'b0, tbl[i].pend, tbl[i].upd, tbl[i].cidx,
           tbl[i].ovf, tbl[i].ea, tbl[i].rd});
    end

    // Core read after an I2C write, then a core write to the top register.
    i2c_write = 1'b1; i2c_index = 8'h43; i2c_wdata = 8'h5C; clr_flags = 1'b1;
    step();
    i2c_write = 1'b0; clr_flags = 1'b0;
    step();
    chk("i2c_commit_43", i2c_rdata, 8'h5C);
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd3;
    step();
    chk("rd_ack_c1", core_ack, 1'b0);
    step();
    chk("rd_ack_c2", {core_ack, core_rdata}, {1'b1, 8'h5C});
    core_req = 1'b0;
    step();
    chk("rd_ack_gone", core_ack, 1'b0);
    core_req = 1'b1; core_we = 1'b1; core_addr = 5'd19;
    core_wdata = 8'h3F; i2c_index = 8'h53;
    step();
    step();
    chk("wr_ack_c2", core_ack, 1'b1);
    core_req = 1'b0;
    chk("wr_visible_53", i2c_rdata, 8'h3F);
    step();

    // Two back-to-back conflicts: I2C wins the first, core the second.
    i2c_write = 1'b1; i2c_index = 8'h41; i2c_wdata = 8'h66; core_lock = 1'b1;
    step();
    i2c_write = 1'b0;
    step();
    i2c_write = 1'b1; i2c_index = 8'h42; i2c_wdata = 8'h77; core_lock = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd1;
    step();
    chk("conf_a", {core_ack, cfg_update, cfg_index, pend_valid, err_ovf},
        {1'b0, 1'b1, 5'd1, 1'b1, 1'b0});
    step();
    chk("conf_b", {core_ack, cfg_update, pend_valid}, {1'b0, 1'b0, 1'b1});
    step();
    chk("conf_c", {core_ack, cfg_update, pend_valid, core_rdata},
        {1'b1, 1'b0, 1'b1, 8'h66});
    core_req = 1'b0; i2c_write = 1'b0;
    step();
    chk("conf_d", {core_ack, cfg_update, cfg_index, pend_valid},
        {1'b0, 1'b1, 5'd2, 1'b0});
    chk("conf_data_42", i2c_rdata, 8'h77);

    // Out-of-range core access still completes, returns zero, flags err_addr.
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0; i2c_index = 8'h45;
    core_req = 1'b1; core_we = 1'b1; core_addr = 5'd25; core_wdata = 8'hFF;
    step();
    step();
    chk("bad_core", {core_ack, core_rdata, err_addr}, {1'b1, 8'h00, 1'b1});
    chk("bad_core_nochg", i2c_rdata, 8'hA7);
    core_req = 1'b0;
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_err", {err_addr, err_ovf}, 2'b00);

    // Asynchronous reset while a write is pending and the core is served.
    core_lock = 1'b1; i2c_write = 1'b1; i2c_index = 8'h44; i2c_wdata = 8'h55;
    step();
    i2c_write = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 5'd0;
    step();
    chk("pre_rst_pend", pend_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {core_rdata, core_ack, cfg_update, cfg_index,
        pend_valid, err_ovf, err_addr}, 32'h0);
    i2c_index = 8'h45;
    #1;
    chk("rst_bank", i2c_rdata, 8'h00);
    rst = 1'b1; core_lock = 1'b0; core_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d", i), {cfg_update, pend_valid, core_ack}, 3'b000);
    end

    // Random traffic against the reference model.
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if (core_req && m_ack) begin
        core_req = 1'b0;
      end else if (!core_req && $urandom_range(2) == 0) begin
        core_req   = 1'b1;
        core_we    = 1'($urandom_range(1));
        core_addr  = 5'($urandom_range(23));
        core_wdata = 8'($urandom);
      end
      if ($urandom_range(3) == 0) i2c_write = ~i2c_write;
      i2c_index = 8'($urandom_range(8'h57, 8'h3C));
      i2c_wdata = 8'($urandom);
      if ($urandom_range(9) == 0) core_lock = ~core_lock;
      clr_flags = ($urandom_range(19) == 0);
      m_edge();
      step();
      chk($sformatf("rnd_ctl%0d", c),
          {core_ack, cfg_update, cfg_index, pend_valid, err_ovf, err_addr},
          {m_ack, m_upd, m_cidx, m_pend.size() != 0, m_ovf, m_ea});
      chk($sformatf("rnd_i2c%0d", c), i2c_rdata, m_read(i2c_index));
      if (m_ack) chk($sformatf("rnd_core%0d", c), core_rdata, m_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
